// File: rtl/vend_dispenser.sv
// Actuator controller for the vending FSM: runs the product motor, then ejects
// change coins through the hopper, supervising every action with a timeout.
module vend_dispenser #(
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 4,
  parameter int TO_W        = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend,
  input  logic [1:0] change,
  input  logic       motor_done,
  input  logic       coin_ack,
  input  logic       fault_clr,
  output logic       busy,
  output logic       motor,
  output logic       coin_req,
  output logic [1:0] coins_left,
  output logic       fault,
  output logic       req_drop
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VEND  = 3'd1,
    COIN  = 3'd2,
    GAP   = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] GAP_LAST = TO_W'(GAP_CYC - 1);

  state_t          state_reg;
  logic [TO_W-1:0] tcnt_reg;
  logic [1:0]      coins_left_reg;
  logic            pend_vend_reg;
  logic            req_drop_reg;
  logic            request;

  assign request = vend | (change != 2'd0);

  // tcnt is shared: timeout in VEND/COIN, gap length in GAP; zeroed on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      tcnt_reg       <= '0;
      coins_left_reg <= 2'd0;
      pend_vend_reg  <= 1'b0;
      req_drop_reg   <= 1'b0;
    end else begin
      req_drop_reg <= (state_reg != IDLE) && request;
      tcnt_reg     <= tcnt_reg + TO_W'(1);
      case (state_reg)
        IDLE: begin
          if (request) begin
            pend_vend_reg  <= vend;
            coins_left_reg <= change;
            tcnt_reg       <= '0;
            state_reg      <= vend ? VEND : COIN;
          end
        end
        VEND: begin
          // A sensor on the timeout cycle wins over the fault.
          if (motor_done) begin
            pend_vend_reg <= 1'b0;
            tcnt_reg      <= '0;
            state_reg     <= (coins_left_reg != 2'd0) ? COIN : IDLE;
          end else if (tcnt_reg == TO_LAST) begin
            tcnt_reg  <= '0;
            state_reg <= FAULT;
          end
        end
        COIN: begin
          if (coin_ack) begin
            if (coins_left_reg != 2'd0) coins_left_reg <= coins_left_reg - 2'd1;
            tcnt_reg  <= '0;
            state_reg <= (coins_left_reg <= 2'd1) ? IDLE : GAP;
          end else if (tcnt_reg == TO_LAST) begin
            tcnt_reg  <= '0;
            state_reg <= FAULT;
          end
        end
        GAP: begin
          if (tcnt_reg == GAP_LAST) begin
            tcnt_reg  <= '0;
            state_reg <= COIN;
          end
        end
        FAULT: begin
          // coins_left is held here so the stalled count can be inspected.
          if (fault_clr) begin
            coins_left_reg <= 2'd0;
            pend_vend_reg  <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = (state_reg != IDLE);
  assign motor      = (state_reg == VEND) && pend_vend_reg;
  assign coin_req   = (state_reg == COIN);
  assign fault      = (state_reg == FAULT);
  assign coins_left = coins_left_reg;
  assign req_drop   = req_drop_reg;

endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: each transaction is expanded into an expected
// per-cycle output trace from the dispensing rules, then replayed and compared.
module tb_vend_dispenser;

  localparam int TIMEOUT_CYC = 64;
  localparam int GAP_CYC     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       vend;
  logic [1:0] change;
  logic       motor_done;
  logic       coin_ack;
  logic       fault_clr;
  logic       busy;
  logic       motor;
  logic       coin_req;
  logic [1:0] coins_left;
  logic       fault;
  logic       req_drop;

  vend_dispenser #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC), .TO_W(7)) dut (
    .clk(clk), .rst(rst), .vend(vend), .change(change),
    .motor_done(motor_done), .coin_ack(coin_ack), .fault_clr(fault_clr),
    .busy(busy), .motor(motor), .coin_req(coin_req), .coins_left(coins_left),
    .fault(fault), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       motor;
    logic       coin_req;
    logic [1:0] cl;
    logic       fault;
    logic       req_drop;
  } exp_t;

  typedef struct packed {
    logic md;
    logic ca;
    logic fc;
    logic inj;
  } drv_t;

  exp_t exp_q[$];
  drv_t drv_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   force_delay = -1;
  bit   prev_inj;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t observed();
    exp_t o;
    o = '{busy, motor, coin_req, coins_left, fault, req_drop};
    return o;
  endfunction

  task automatic check(input string tag, input exp_t obs, input exp_t req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed{busy,motor,coin_req,cl,fault,drop}=%b required=%b",
             tag, cyc, obs, req);
    end
  endtask

  // Sensor delay in cycles after the drive rises; 64 means the sensor never comes.
  function automatic int pick_delay();
    int r;
    if (force_delay >= 0) return force_delay;
    r = $urandom_range(0, 19);
    if (r == 0) return TIMEOUT_CYC;
    if (r == 1) return TIMEOUT_CYC - 1;
    return $urandom_range(0, 3);
  endfunction

  task automatic push(input logic b, input logic m, input logic cr, input logic [1:0] cl,
                      input logic f, input logic md, input logic ca, input logic fc,
                      input bit last);
    exp_t e;
    drv_t d;
    bit   inj;
    inj = last ? 1'b0 : ($urandom_range(0, 7) == 0);
    e = '{b, m, cr, cl, f, prev_inj};
    d = '{md, ca, fc, inj};
    exp_q.push_back(e);
    drv_q.push_back(d);
    prev_inj = inj;
  endtask

  function automatic logic rnd_clr();
    return ($urandom_range(0, 7) == 0);
  endfunction

  // Expand one request into the cycle-by-cycle trace the dispenser must produce.
  task automatic build(input logic v, input logic [1:0] c);
    int d, n, left, nf;
    bit faulted;
    exp_q.delete();
    drv_q.delete();
    prev_inj = 1'b0;
    faulted  = 1'b0;
    left     = c;
    if (v) begin
      d = pick_delay();
      n = (d >= TIMEOUT_CYC) ? TIMEOUT_CYC : d + 1;
      for (int i = 0; i < n; i++)
        push(1, 1, 0, 2'(left), 0, (d < TIMEOUT_CYC) && (i == n - 1), 0, rnd_clr(), 0);
      faulted = (d >= TIMEOUT_CYC);
    end
    while (!faulted && left > 0) begin
      d = pick_delay();
      n = (d >= TIMEOUT_CYC) ? TIMEOUT_CYC : d + 1;
      for (int i = 0; i < n; i++)
        push(1, 0, 1, 2'(left), 0, 0, (d < TIMEOUT_CYC) && (i == n - 1), rnd_clr(), 0);
      if (d >= TIMEOUT_CYC) faulted = 1'b1;
      else begin
        left--;
        if (left > 0)
          for (int i = 0; i < GAP_CYC; i++)
            push(1, 0, 0, 2'(left), 0, 0, $urandom_range(0, 1) == 1, rnd_clr(), 0);
      end
    end
    if (faulted) begin
      nf = $urandom_range(1, 3);
      for (int i = 0; i < nf; i++)
        push(1, 0, 0, 2'(left), 1, 0, 0, i == nf - 1, 0);
    end
    push(0, 0, 0, 2'd0, 0, 0, 0, 0, 1);
  endtask

  task automatic run_tx(input string tag, input logic v, input logic [1:0] c);
    build(v, c);
    vend   = v;
    change = c;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        vend   = 1'b0;
        change = 2'd0;
      end
      check(tag, observed(), exp_q[i]);
      motor_done = drv_q[i].md;
      coin_ack   = drv_q[i].ca;
      fault_clr  = drv_q[i].fc;
      vend       = drv_q[i].inj;
    end
    $display("tx %s vend=%0b change=%0d cycles=%0d failures=%0d", tag, v, c, exp_q.size(), failures);
  endtask

  initial begin
    exp_t zero;
    logic v;
    logic [1:0] c;
    zero = '0;
    rst = 1'b1; vend = 1'b1; change = 2'd2;
    motor_done = 1'b0; coin_ack = 1'b0; fault_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset", observed(), zero);
    end
    rst = 1'b0; vend = 1'b0; change = 2'd0;
    @(posedge clk); #1;
    check("post_reset_idle", observed(), zero);
    $display("tx reset checks=%0d failures=%0d", checks, failures);

    force_delay = 2;           run_tx("vend_only", 1'b1, 2'd0);
    force_delay = 1;           run_tx("refund2", 1'b0, 2'd2);
    force_delay = TIMEOUT_CYC; run_tx("motor_timeout", 1'b1, 2'd3);
    force_delay = TIMEOUT_CYC - 1; run_tx("edge_ack", 1'b0, 2'd3);
    force_delay = TIMEOUT_CYC - 1; run_tx("edge_motor", 1'b1, 2'd1);

    // Reset in the middle of a coin eject drops every drive on the next edge.
    force_delay = -1;
    vend = 1'b0; change = 2'd2;
    @(posedge clk); #1;
    change = 2'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_coin_reset", observed(), zero);
    rst = 1'b0;
    $display("tx mid_coin_reset failures=%0d", failures);

    for (int t = 0; t < 40; t++) begin
      v = 1'($urandom_range(0, 1));
      c = 2'($urandom_range(0, 3));
      if (!v && c == 2'd0) c = 2'd1;
      run_tx("random", v, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Output-side actuator controller for the coin-operated vending FSM.
- Consumes the FSM's product strobe and change code (in 5-unit coins), then drives the product motor and the coin hopper through sensor handshakes.
- Supervises each mechanical action with a timeout and latches a fault on jam or empty hopper.
- Sits between the vending FSM and the motor/hopper driver pins.

Parameters:
- TIMEOUT_CYC, 64: max cycles any motor or hopper action may wait for its sensor; min 2.
- GAP_CYC, 4: idle cycles with coin_req low between consecutive coin ejects; min 1.
- TO_W, 7: width of the shared timeout/gap counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- vend  in  1  product-release request, sampled every cycle
- change  in  2  number of 5-unit coins to return (0..3), sampled with a request
- motor_done  in  1  product-drop sensor
- coin_ack  in  1  hopper coin-exit sensor, one pulse per coin
- fault_clr  in  1  clears a latched fault
- busy  out  1  high in any state other than IDLE
- motor  out  1  product motor drive
- coin_req  out  1  hopper eject request
- coins_left  out  2  coins still to be ejected
- fault  out  1  latched timeout fault
- req_drop  out  1  one-cycle pulse when a request arrives while not IDLE

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; counters cleared.
  - busy, motor, coin_req, fault and req_drop=0; coins_left=0.
  - Reset wins over every other input, including mid-action; all drives drop on the next edge.
- Outputs are Moore-decoded from registered state:
  - motor = (state==VEND)
  - coin_req = (state==COIN)
  - fault = (state==FAULT)
  - busy = (state!=IDLE)
- Request: in IDLE, request = vend | (change!=0).
  - Captured at edge N: pend_vend<=vend, coins_left<=change.
  - Next state is VEND if vend=1, else COIN. Drives are high from cycle N+1.
  - Request while not IDLE is ignored and req_drop=1 for one cycle; coins_left is unchanged.
- VEND:
  - motor=1; tcnt increments each cycle, and tcnt=0 on every state entry.
  - On motor_done=1: go to COIN if coins_left!=0, else IDLE.
  - If tcnt reaches TIMEOUT_CYC-1 without motor_done: go to FAULT.
- COIN:
  - coin_req=1.
  - On coin_ack=1: coins_left decrements. Next state is IDLE if the decremented value is 0, else GAP.
  - coin_req drops on the cycle after the ack.
  - Timeout as in VEND, leading to FAULT.
- GAP: stays for exactly GAP_CYC cycles with coin_req=0, then returns to COIN. coin_ack in GAP is ignored; a spurious coin does not count.
- FAULT:
  - All drives are 0; coins_left holds its value for diagnostics.
  - Exit on fault_clr=1 to IDLE, with coins_left<=0 and pend_vend<=0.
  - Requests during FAULT produce req_drop.
- Simultaneous events:
  - A sensor arriving on the same cycle the timeout is reached wins; no fault.
  - fault_clr outside FAULT has no effect.
- Arithmetic: coins_left never decrements below 0; change=2'b11 is legal and ejects 3 coins.
- Latency (zero-delay sensors): vend-only completes in 2 cycles; each extra coin adds 1+GAP_CYC cycles.

Test Plan:
- rst=1 for 2 cycles with vend=1, change=2 → all outputs 0, state IDLE; motor never rises.
- vend=1, change=0 at cycle 0; motor_done at cycle 3 → motor high cycles 1-3, busy=0 at cycle 4, coin_req never asserted.
- vend=0, change=2 (refund); coin_ack 2 cycles after each coin_req rise → two coin_req pulses separated by 4 low cycles; coins_left goes 2→1→0; busy falls after the second ack.
- vend=1, change=3, motor_done never asserted → motor high for exactly 64 cycles, then fault=1, coins_left=3. fault_clr=1 → IDLE, coins_left=0, fault=0.
- While busy in COIN, assert vend=1 → req_drop pulses once; coins_left is unchanged and the in-progress sequence completes normally.
- coin_ack asserted on the exact cycle tcnt=63 → no fault, count decrements. Separately, assert rst mid-COIN → coin_req=0 and coins_left=0 on the next edge.
